result_collect: RTL and testbench

- Many-to-one merger: the return-path counterpart of the read dispatcher. CH per-core result streams are merged into one output stream toward the DMA writer.
- Arbitration is round-robin, packet-atomic on `last`.
- Each output beat carries the source channel index so software can reorder results.
- A single registered output stage gives 1-cycle latency and full throughput.

---
 rtl/rd_pkg.sv | 14 +
 rtl/result_collect_rr_arbiter.sv | 48 ++++
 rtl/result_collect.sv | 88 ++++++++
 tb/tb_result_collect.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_pkg.sv
// Shared helpers and types for the result-collect return path.
package rd_pkg;

    localparam int ID_W_MAX = 6;
    localparam int CH_MAX   = 64;

    // Channel-id width never drops to zero, so a single-channel build still has a 1-bit id.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [clog2_min1(CH_MAX)-1:0] ch_id_t;

endpackage

// File: rtl/result_collect_rr_arbiter.sv
// Round-robin grant with packet lock: double-width masked priority encoder.
module rr_arbiter
    import rd_pkg::*;
#(
    parameter  int CH = 16,
    localparam int IW = clog2_min1(CH)
) (
    input  logic [CH-1:0] i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic          i_lock_en,
    input  logic [IW-1:0] i_lock_ch,
    output logic [CH-1:0] o_grant,
    output logic [IW-1:0] o_grant_idx
);

    logic [CH-1:0]   w_mask;
    logic [2*CH-1:0] w_dbl;
    logic            w_found;
    int              w_pos;
    int              w_idx;

    always_comb begin
        w_mask  = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_idx   = 0;
        for (int i = 0; i < CH; i++) begin
            w_mask[i] = (i >= int'(i_ptr));
        end
        // Low half holds requests at or above ptr; the high half is the wrapped fallback.
        w_dbl = {i_req, i_req & w_mask};
        for (int i = 0; i < 2*CH; i++) begin
            if (!w_found && w_dbl[i]) begin
                w_found = 1'b1;
                w_pos   = i;
            end
        end
        w_idx = (w_pos >= CH) ? (w_pos - CH) : w_pos;

        o_grant     = w_found ? (CH'(1) << w_idx) : '0;
        o_grant_idx = IW'(w_idx);
        if (i_lock_en) begin
            o_grant     = i_req & (CH'(1) << i_lock_ch);
            o_grant_idx = i_lock_ch;
        end
    end

endmodule

// File: rtl/result_collect.sv
// Many-to-one merge of per-core result streams with a single registered output stage.
module result_collect
    import rd_pkg::*;
#(
    parameter  int CH = 16,
    parameter  int DW = 512,
    localparam int IW = clog2_min1(CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] ri_data [CH],
    input  logic [CH-1:0] ri_last,
    input  logic [CH-1:0] ri_valid,
    output logic [CH-1:0] ri_ready,
    output logic [DW-1:0] ro_data,
    output logic [IW-1:0] ro_id,
    output logic          ro_last,
    output logic          ro_valid,
    input  logic          ro_ready
);

    logic [DW-1:0] r_data;
    logic [IW-1:0] r_id;
    logic          r_last;
    logic          r_valid;
    logic [IW-1:0] r_ptr;
    logic          r_locked;
    logic [IW-1:0] r_lock_ch;

    logic [CH-1:0] w_grant;
    logic [IW-1:0] w_grant_idx;
    logic          w_adv;
    logic          w_xfer;
    logic          w_sel_last;

    rr_arbiter #(.CH(CH)) u_arb (
        .i_req       (ri_valid),
        .i_ptr       (r_ptr),
        .i_lock_en   (r_locked),
        .i_lock_ch   (r_lock_ch),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // A grant only exists for a valid channel, so any ready bit means a transfer.
    assign w_adv      = ~r_valid | ro_ready;
    assign ri_ready   = w_grant & {CH{w_adv & rst_n}};
    assign w_xfer     = |ri_ready;
    assign w_sel_last = ri_last[w_grant_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_id    <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_data  <= ri_data[w_grant_idx];
            r_id    <= w_grant_idx;
            r_last  <= w_sel_last;
            r_valid <= 1'b1;
        end else if (ro_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_locked  <= 1'b0;
            r_lock_ch <= '0;
        end else if (w_xfer) begin
            if (w_sel_last) begin
                r_locked <= 1'b0;
                r_ptr    <= (w_grant_idx == IW'(CH-1)) ? '0 : w_grant_idx + IW'(1);
            end else begin
                r_locked  <= 1'b1;
                r_lock_ch <= w_grant_idx;
            end
        end
    end

    assign ro_data  = r_data;
    assign ro_id    = r_id;
    assign ro_last  = r_last;
    assign ro_valid = r_valid;

endmodule

// File: tb/tb_result_collect.sv
// Directed bench for result_collect: reset, rotation, packet lock, stalls, wrap, reset mid-packet.
module tb_result_collect;
  localparam int CH = 16;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] ri_data [CH];
  logic [CH-1:0] ri_last;
  logic [CH-1:0] ri_valid;
  logic [CH-1:0] ri_ready;
  logic [DW-1:0] ro_data;
  logic [IW-1:0] ro_id;
  logic          ro_last;
  logic          ro_valid;
  logic          ro_ready;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  result_collect #(.CH(CH), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ri_data  (ri_data),
    .ri_last  (ri_last),
    .ri_valid (ri_valid),
    .ri_ready (ri_ready),
    .ro_data  (ro_data),
    .ro_id    (ro_id),
    .ro_last  (ro_last),
    .ro_valid (ro_valid),
    .ro_ready (ro_ready)
  );

  function automatic logic [DW-1:0] pat(input int ch, input int seq);
    return 32'hC0DE_0000 | DW'(seq << 8) | DW'(ch);
  endfunction

  // driver tasks
  task automatic idle_inputs();
    ri_valid = '0;
    ri_last  = '1;
    for (int i = 0; i < CH; i++) ri_data[i] = pat(i, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    ro_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ri_valid = '1;
    ri_last  = '1;
    for (int i = 0; i < CH; i++) ri_data[i] = pat(i, 0);
    ro_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (ri_ready !== '0) begin
        n_errors++;
        $display("FAIL reset_ready cyc%0d: got %h expected 0", c, ri_ready);
      end
      @(negedge clk);
      n_checks++;
      if (ro_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_valid cyc%0d: got %b expected 0", c, ro_valid);
      end
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ri_ready !== 16'h0001) begin
      n_errors++;
      $display("FAIL reset_first_grant: got %h expected 0001", ri_ready);
    end
    @(negedge clk);
    n_checks++;
    if (ro_valid !== 1'b1 || ro_id !== 4'd0 || ro_data !== pat(0, 0)) begin
      n_errors++;
      $display("FAIL reset_first_beat: got v=%b id=%0d d=%h expected v=1 id=0 d=%h",
               ro_valid, ro_id, ro_data, pat(0, 0));
    end
    ri_valid = '0;
    @(negedge clk);
    n_checks++;
    if (ro_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_drain: got v=%b expected 0", ro_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    ri_valid = '1;
    ri_last  = '1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      n_checks++;
      if (ro_valid !== 1'b1 || ro_id !== IW'(k % CH) || ro_data !== pat(k % CH, 0) || ro_last !== 1'b1) begin
        n_errors++;
        $display("FAIL rr_beat%0d: got v=%b id=%0d d=%h l=%b expected v=1 id=%0d d=%h l=1",
                 k, ro_valid, ro_id, ro_data, ro_last, k % CH, pat(k % CH, 0));
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_packet_lock();
    logic [5:0] v3_sched;
    int b;
    v3_sched = 6'b110011;
    b = 0;
    do_reset();
    for (int i = 4; i < 8; i++) ri_valid[i] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      ri_valid[3] = v3_sched[c];
      ri_data[3]  = pat(3, b);
      ri_last[3]  = (b == 3);
      #1;
      if (!v3_sched[c]) begin
        n_checks++;
        if (ri_ready !== '0) begin
          n_errors++;
          $display("FAIL lock_gap_ready cyc%0d: got %h expected 0", c, ri_ready);
        end
      end
      @(negedge clk);
      n_checks++;
      if (v3_sched[c]) begin
        if (ro_valid !== 1'b1 || ro_id !== 4'd3 || ro_data !== pat(3, b) || ro_last !== (b == 3)) begin
          n_errors++;
          $display("FAIL lock_beat%0d: got v=%b id=%0d d=%h l=%b expected v=1 id=3 d=%h l=%b",
                   b, ro_valid, ro_id, ro_data, ro_last, pat(3, b), (b == 3));
        end
        b++;
      end else if (ro_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL lock_gap_valid cyc%0d: got v=%b id=%0d expected v=0", c, ro_valid, ro_id);
      end
    end
    ri_valid[3] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ro_valid !== 1'b1 || ro_id !== 4'd4 || ro_data !== pat(4, 0)) begin
      n_errors++;
      $display("FAIL lock_next: got v=%b id=%0d d=%h expected v=1 id=4 d=%h",
               ro_valid, ro_id, ro_data, pat(4, 0));
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [IW+DW-1:0] exp_q[$];
    logic [IW+DW-1:0] exp;
    logic [3:0]       rdy_pat;
    logic [CH-1:0]    acc;
    logic             stall_prev;
    logic [DW-1:0]    s_data;
    logic [IW-1:0]    s_id;
    logic             s_last;
    int seq0, seq1, cyc;
    rdy_pat = 4'b1001;
    seq0 = 0;
    seq1 = 0;
    cyc = 0;
    stall_prev = 1'b0;
    s_data = '0;
    s_id = '0;
    s_last = 1'b0;
    for (int s = 0; s < NB; s++) begin
      exp_q.push_back({4'd0, pat(0, s)});
      exp_q.push_back({4'd1, pat(1, s)});
    end
    do_reset();
    while (exp_q.size() > 0 && cyc < 80) begin
      ro_ready    = rdy_pat[cyc % 4];
      ri_valid[0] = (seq0 < NB);
      ri_data[0]  = pat(0, seq0);
      ri_valid[1] = (seq1 < NB);
      ri_data[1]  = pat(1, seq1);
      #1;
      if (stall_prev) begin
        n_checks++;
        if (ro_valid !== 1'b1 || ro_id !== s_id || ro_data !== s_data || ro_last !== s_last) begin
          n_errors++;
          $display("FAIL bp_stable cyc%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                   cyc, ro_valid, ro_id, ro_data, s_id, s_data);
        end
      end
      acc = ri_valid & ri_ready;
      if (ro_valid === 1'b1 && ro_ready) begin
        exp = exp_q.pop_front();
        n_checks++;
        if ({ro_id, ro_data} !== exp || ro_last !== 1'b1) begin
          n_errors++;
          $display("FAIL bp_order cyc%0d: got id=%0d d=%h expected id=%0d d=%h",
                   cyc, ro_id, ro_data, exp[IW+DW-1:DW], exp[DW-1:0]);
        end
      end
      stall_prev = (ro_valid === 1'b1) && !ro_ready;
      s_data = ro_data;
      s_id   = ro_id;
      s_last = ro_last;
      @(negedge clk);
      if (acc[0]) seq0++;
      if (acc[1]) seq1++;
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL bp_timeout: got %0d beats left expected 0", exp_q.size());
    end
    idle_inputs();
    ro_ready = 1'b1;
    #1;
    n_checks++;
    if (ro_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_extra_beat: got v=%b id=%0d expected v=0", ro_valid, ro_id);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap_sparse();
    int exp_id;
    do_reset();
    ri_valid[14] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ro_valid !== 1'b1 || ro_id !== 4'd14) begin
      n_errors++;
      $display("FAIL wrap_setup: got v=%b id=%0d expected v=1 id=14", ro_valid, ro_id);
    end
    ri_valid[14] = 1'b0;
    ri_valid[15] = 1'b1;
    ri_valid[0]  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 0) ? 15 : 0;
      @(negedge clk);
      n_checks++;
      if (ro_valid !== 1'b1 || ro_id !== IW'(exp_id) || ro_data !== pat(exp_id, 0)) begin
        n_errors++;
        $display("FAIL wrap_beat%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                 k, ro_valid, ro_id, ro_data, exp_id, pat(exp_id, 0));
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    ri_valid[5] = 1'b1;
    ri_last[5]  = 1'b0;
    ri_data[5]  = pat(5, 0);
    @(negedge clk);
    n_checks++;
    if (ro_valid !== 1'b1 || ro_id !== 4'd5 || ro_last !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_beat0: got v=%b id=%0d l=%b expected v=1 id=5 l=0", ro_valid, ro_id, ro_last);
    end
    ri_data[5] = pat(5, 1);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ri_ready !== '0) begin
      n_errors++;
      $display("FAIL mid_ready_in_reset: got %h expected 0", ri_ready);
    end
    @(negedge clk);
    n_checks++;
    if (ro_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_valid_cleared: got v=%b expected 0", ro_valid);
    end
    rst_n = 1'b1;
    ri_valid[2] = 1'b1;
    ri_last[2]  = 1'b1;
    ri_data[2]  = pat(2, 0);
    #1;
    n_checks++;
    if (ri_ready !== 16'h0004) begin
      n_errors++;
      $display("FAIL mid_grant_after: got %h expected 0004", ri_ready);
    end
    @(negedge clk);
    n_checks++;
    if (ro_valid !== 1'b1 || ro_id !== 4'd2 || ro_data !== pat(2, 0)) begin
      n_errors++;
      $display("FAIL mid_beat_after: got v=%b id=%0d d=%h expected v=1 id=2 d=%h",
               ro_valid, ro_id, ro_data, pat(2, 0));
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    ro_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_wrap_sparse();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
